// File: rtl/quad_encoder_frontend.sv
// Quadrature encoder front end: per-channel synchroniser and debounce filter,
// Gray-code decoder with detent accumulator, one-cycle step pulses and sticky error.
module quad_encoder_frontend #(
    parameter int DEBOUNCE         = 4,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       en,
    input  logic       err_clr,
    output logic       step_en,
    output logic       step_dn,
    output logic       err,
    output logic [1:0] state
);

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [8:0] ARM_LAST = 9'(DEBOUNCE + 3);
    localparam logic [3:0] STEPS_N  = 4'(STEPS_PER_DETENT);

    logic [1:0] raw_in;
    logic [1:0] filt;

    assign raw_in = {enc_a, enc_b};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic       s1_q, s2_q;
        logic       f_q, f_d;
        logic [7:0] cnt_q, cnt_d;

        // A glitch that returns before acceptance drops the count back to zero.
        always_comb begin
            f_d   = f_q;
            cnt_d = cnt_q;
            if (s2_q == f_q) begin
                cnt_d = 8'd0;
            end else if (cnt_q == DB_LAST) begin
                f_d   = s2_q;
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                f_q   <= 1'b0;
                cnt_q <= 8'd0;
            end else begin
                s1_q  <= raw_in[gi];
                s2_q  <= s1_q;
                f_q   <= f_d;
                cnt_q <= cnt_d;
            end
        end

        assign filt[gi] = f_q;
    end

    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        case (g)
            2'b00:   gray_pos = 2'd0;
            2'b01:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    logic [1:0] prev_q, prev_d;
    logic [3:0] acc_q, acc_d;
    logic       acc_dir_q, acc_dir_d;
    logic [8:0] arm_q, arm_d;
    logic       step_en_q, step_en_d;
    logic       step_dn_q, step_dn_d;
    logic       err_q, err_d;

    logic       armed;
    logic [1:0] pos_diff;
    logic       dir;
    logic [3:0] n;

    assign armed    = (arm_q == ARM_LAST);
    // Position delta around the Gray cycle: 1 = forward, 3 = reverse, 2 = both bits flipped.
    assign pos_diff = gray_pos(filt) - gray_pos(prev_q);
    assign dir      = (pos_diff == 2'd3);

    always_comb begin
        arm_d     = armed ? arm_q : arm_q + 9'd1;
        prev_d    = filt;
        acc_d     = acc_q;
        acc_dir_d = acc_dir_q;
        step_en_d = 1'b0;
        step_dn_d = step_dn_q;
        err_d     = err_clr ? 1'b0 : err_q;
        n         = 4'd0;
        if (!armed) begin
            acc_d = 4'd0;
        end else if (pos_diff == 2'd2) begin
            err_d = 1'b1;
            acc_d = 4'd0;
        end else if (!en) begin
            acc_d = 4'd0;
        end else if (pos_diff != 2'd0) begin
            n         = (acc_q != 4'd0 && dir == acc_dir_q) ? acc_q + 4'd1 : 4'd1;
            acc_dir_d = dir;
            if (n == STEPS_N) begin
                step_en_d = 1'b1;
                step_dn_d = dir;
                acc_d     = 4'd0;
            end else begin
                acc_d = n;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q    <= 2'b00;
            acc_q     <= 4'd0;
            acc_dir_q <= 1'b0;
            arm_q     <= 9'd0;
            step_en_q <= 1'b0;
            step_dn_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            acc_q     <= acc_d;
            acc_dir_q <= acc_dir_d;
            arm_q     <= arm_d;
            step_en_q <= step_en_d;
            step_dn_q <= step_dn_d;
            err_q     <= err_d;
        end
    end

    assign step_en = step_en_q;
    assign step_dn = step_dn_q;
    assign err     = err_q;
    assign state   = filt;

endmodule

// File: doc/quad_encoder_frontend.md
Name: quad_encoder_frontend

Overview:
Front end for the up/down step counter. Takes raw, bouncy quadrature encoder inputs (A/B) from io pins. Synchronises and debounces each channel, then decodes Gray-code transitions. Emits one-cycle step pulses with a direction flag that drive the counter's enable and updown inputs directly. Also flags illegal transitions.

Parameters:
DEBOUNCE, 4, consecutive cycles a synchronised input must differ from its filtered value before the filter accepts it (1..255)
STEPS_PER_DETENT, 4, valid same-direction transitions per emitted step (1..15)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
enc_a  input  1  raw encoder channel A, asynchronous to clock
enc_b  input  1  raw encoder channel B, asynchronous to clock
en  input  1  step emission enable
err_clr  input  1  clears sticky err
step_en  output  1  one-cycle step pulse (to counter enable)
step_dn  output  1  direction: 0 = up, 1 = down (to counter updown)
err  output  1  sticky illegal-transition flag
state  output  2  filtered {A,B}, debug

Behaviour:
- Reset (reset==0, async): all flops to 0 (synchronisers, filters, debounce counters, prev state, accumulator, arm counter, step_en, step_dn, err). state = 2'b00.
- Synchroniser: two flops per channel (s1, s2). Nothing else samples enc_a or enc_b.
- Debounce, per channel, with counter cnt:
  - If s2 == f: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: f <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch that returns before acceptance restarts the count.
- Latency: a raw change first captured at edge 0 updates f at edge 1+DEBOUNCE. step_en is high in the cycle following edge 2+DEBOUNCE.
- Arming: an arm counter runs from reset release and saturates at DEBOUNCE+3 ("armed").
  - While unarmed: prev <= f every cycle, no steps, no err, accumulator held at 0.
  - This avoids spurious events when the encoder rests at a nonzero position out of reset.
- Decode (armed): compare prev {pa,pb} with cur {fa,fb} each cycle, then prev <= cur.
  - Forward (up, d=0): 00->01->11->10->00.
  - Reverse (down, d=1): the opposite order.
  - No change: nothing.
  - Both bits changed: illegal. err <= 1, accumulator cleared, no step.
- Accumulator: acc (4 bits) plus acc_dir. On a valid transition with direction d:
  - n = (acc != 0 && d == acc_dir) ? acc+1 : 1.
  - If n == STEPS_PER_DETENT: emit step, acc <= 0.
  - Else: acc <= n.
  - acc_dir <= d in both cases.
  - A direction reversal mid-detent discards partial progress and counts the new transition as 1.
- Emit: step_en <= 1 for exactly one cycle; step_dn <= d in the same edge. step_dn holds its last value otherwise. step_en <= 0 on all non-emit cycles.
- en == 0:
  - Transitions are still decoded and prev is still updated.
  - Nothing is emitted, acc <= 0.
  - Illegal transitions still set err.
- err is sticky. err_clr clears it. An illegal transition in the same cycle as err_clr leaves err = 1 (set wins).
- Maximum step rate: one per cycle per decoder update. Back-to-back pulses are legal only if STEPS_PER_DETENT == 1.

Test Plan:
1. DEBOUNCE=4, STEPS=1: after arming, drive A/B through the full forward cycle, holding each state 10 cycles -> 4 step_en pulses, each 1 cycle wide, step_dn=0. First pulse appears 7 cycles (DEBOUNCE+3 edges) after the first input edge.
2. DEBOUNCE=4, STEPS=4: drive one full reverse cycle (00->10->11->01->00) -> exactly one pulse, step_dn=1, coincident with the 4th transition. Then 3 forward transitions -> no pulse.
3. Bounce: toggle enc_a every 2 cycles for 20 cycles, then settle high -> no filter change during the toggling. state becomes 2'b10 exactly 6 edges after the final edge. At most one transition is decoded.
4. Illegal: with DEBOUNCE=1, step A and B together 00->11 -> err=1, no step_en. Assert err_clr for 1 cycle -> err=0. Repeat with err_clr held high during the illegal edge -> err stays 1.
5. Power-on at 11: hold enc_a = enc_b = 1 through reset release -> no err and no step_en ever. state reads 2'b11 once armed.
6. Reset mid-operation: STEPS=4, after 3 forward transitions pull reset low for 1 cycle, then do 1 more transition -> no pulse, step_en/step_dn/err all 0 immediately on reset assertion.
